// File: rtl/i2s_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tdm_tx
// Description : I2S / left-justified / TDM serial audio transmitter with a
//               one-frame holding buffer and underflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_tx #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int CHANNELS  = 2,
  parameter int BCK_DIV   = 8,
  parameter int LEFT_JUST = 0,
  parameter int UF_REPEAT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         I2S_BCK,
  output logic                         I2S_LRCK,
  output logic                         I2S_DATA,
  output logic                         frame_start,
  output logic                         underflow
);

  localparam int FRAME_BITS = CHANNELS * SLOT_W;
  localparam int IN_W       = CHANNELS * SAMPLE_W;
  localparam int DIV_W      = $clog2(BCK_DIV);
  localparam int POS_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] SLOT_LEN = POS_W'(SLOT_W);

  // Lays the channels out MSB-first, one slot each, zero-padding below each sample.
  function automatic logic [FRAME_BITS-1:0] to_image(input logic [IN_W-1:0] f);
    logic [FRAME_BITS-1:0] img;
    img = '0;
    for (int s = 0; s < CHANNELS; s++)
      img[FRAME_BITS-1-s*SLOT_W -: SAMPLE_W] = f[s*SAMPLE_W +: SAMPLE_W];
    return img;
  endfunction

  logic [DIV_W-1:0]      div;
  logic [POS_W-1:0]      pos;
  logic [FRAME_BITS-1:0] shifter;
  logic [IN_W-1:0]       holding;
  logic [IN_W-1:0]       last;
  logic                  holding_full;
  logic                  primed;

  logic                  wrap;
  logic                  load;
  logic                  accept;
  logic [DIV_W-1:0]      div_nxt;
  logic [POS_W-1:0]      pos_nxt;
  logic [POS_W-1:0]      lr_pos;
  logic [FRAME_BITS-1:0] load_img;
  logic [FRAME_BITS-1:0] shift_src;
  logic                  lrck_nxt;

  // pos is the data position that will be presented at the next div wrap.
  always_comb begin
    wrap    = (div == DIV_LAST);
    div_nxt = wrap ? '0 : div + DIV_W'(1);
    pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    load    = wrap && (pos == '0);
    accept  = sample_valid && sample_ready;

    if (holding_full)        load_img = to_image(holding);
    else if (UF_REPEAT != 0) load_img = to_image(last);
    else                     load_img = '0;

    shift_src = load ? load_img : shifter;
    lr_pos    = (LEFT_JUST != 0) ? pos : pos_nxt;

    if (CHANNELS == 2) lrck_nxt = (lr_pos >= SLOT_LEN);
    else               lrck_nxt = (lr_pos == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div          <= '0;
      pos          <= '0;
      shifter      <= '0;
      holding      <= '0;
      last         <= '0;
      holding_full <= 1'b0;
      primed       <= 1'b0;
      sample_ready <= 1'b1;
      I2S_BCK      <= 1'b0;
      I2S_LRCK     <= 1'b0;
      I2S_DATA     <= 1'b0;
      frame_start  <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      div         <= div_nxt;
      I2S_BCK     <= (div_nxt >= DIV_HALF);
      frame_start <= 1'b0;
      underflow   <= 1'b0;

      if (wrap) begin
        pos      <= pos_nxt;
        I2S_DATA <= shift_src[FRAME_BITS-1];
        I2S_LRCK <= lrck_nxt;
        shifter  <= shift_src << 1;
      end

      if (load) begin
        frame_start <= 1'b1;
        if (holding_full) begin
          last   <= holding;
          primed <= 1'b1;
        end else begin
          underflow <= primed;
        end
      end

      // A same-clock accept and load never bypass: the load already saw an empty buffer.
      if (accept) begin
        holding      <= sample_in;
        holding_full <= 1'b1;
        sample_ready <= 1'b0;
      end else if (load && holding_full) begin
        holding_full <= 1'b0;
        sample_ready <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tdm_tx
// Description : Bench for i2s_tdm_tx across stereo I2S, left-justified and TDM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int cfg_ch(input int i); return (i == 2) ? 4 : 2; endfunction
  function automatic int cfg_sl(input int i); return (i == 1) ? 32 : 16; endfunction
  function automatic int cfg_bd(input int i); return (i == 0) ? 4 : ((i == 1) ? 2 : 6); endfunction
  function automatic int cfg_lj(input int i); return (i == 1) ? 1 : 0; endfunction
  function automatic int cfg_ur(input int i); return (i == 1) ? 1 : 0; endfunction

  function automatic logic [63:0] cfg_first(input int i);
    if (i == 0) return 64'h0000_0000_0F01_A5C3;
    if (i == 1) return 64'h0000_0000_C003_8001;
    return 64'h4444_3333_2222_1111;
  endfunction

  // Serial stream of the first frame, first-sent bit in the MSB.
  function automatic logic [63:0] cfg_lit(input int i);
    if (i == 0) return 64'h0000_0000_A5C3_0F01;
    if (i == 1) return 64'h8001_0000_C003_0000;
    return 64'h1111_2222_3333_4444;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int CH = cfg_ch(gi);
      localparam int SW = 16;
      localparam int SL = cfg_sl(gi);
      localparam int BD = cfg_bd(gi);
      localparam int LJ = cfg_lj(gi);
      localparam int UR = cfg_ur(gi);
      localparam int FB = CH * SL;
      localparam int FP = FB * BD;
      localparam int IW = CH * SW;

      logic          rst   = 1'b1;
      logic          valid = 1'b0;
      logic [IW-1:0] din   = '0;
      logic          ready, bck, lrck, data, fs, uf;

      i2s_tdm_tx #(
        .SAMPLE_W (SW), .SLOT_W (SL), .CHANNELS (CH),
        .BCK_DIV  (BD), .LEFT_JUST (LJ), .UF_REPEAT (UR)
      ) u_dut (
        .clk          (clk),
        .reset        (rst),
        .sample_in    (din),
        .sample_valid (valid),
        .sample_ready (ready),
        .I2S_BCK      (bck),
        .I2S_LRCK     (lrck),
        .I2S_DATA     (data),
        .frame_start  (fs),
        .underflow    (uf)
      );

      int            k = 0;
      logic [IW-1:0] hold_q[$];
      logic [IW-1:0] cur  = '0;
      logic [IW-1:0] last = '0;
      bit            primed  = 1'b0;
      bit            e_bck   = 1'b0;
      bit            e_lrck  = 1'b0;
      bit            e_data  = 1'b0;
      bit            e_fs    = 1'b0;
      bit            e_uf    = 1'b0;
      bit            e_ready = 1'b1;
      logic [63:0]   cap  = '0;
      bit            done = 1'b0;

      task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", gi, nm, act, exp, $time);
      endtask

      function automatic logic exp_bit(input logic [IW-1:0] f, input int d);
        int s, b;
        s = d / SL;
        b = d % SL;
        if (b >= SW) return 1'b0;
        return f[s*SW + SW-1-b];
      endfunction

      function automatic logic exp_lrck(input int d);
        int p;
        p = (LJ != 0) ? d : (d + 1) % FB;
        if (CH == 2) return (p >= SL);
        return (p == 0);
      endfunction

      function automatic logic [IW-1:0] rnd();
        return IW'({$urandom(), $urandom()});
      endfunction

      // k counts clk edges since reset release; wraps fall on multiples of BD.
      initial begin : mdl
        bit            acc;
        logic [IW-1:0] a_in;
        int            n, d;
        forever begin
          @(posedge clk);
          if (rst) begin
            k = 0; hold_q.delete(); cur = '0; last = '0; primed = 1'b0;
            e_bck = 0; e_lrck = 0; e_data = 0; e_fs = 0; e_uf = 0; e_ready = 1;
          end else begin
            acc  = valid && (hold_q.size() == 0);
            a_in = din;
            k++;
            e_fs  = 1'b0;
            e_uf  = 1'b0;
            e_bck = ((k % BD) >= BD / 2);
            if (k % BD == 0) begin
              n = k / BD - 1;
              d = n % FB;
              if (d == 0) begin
                e_fs = 1'b1;
                if (hold_q.size() > 0) begin
                  cur = hold_q.pop_front(); last = cur; primed = 1'b1;
                end else begin
                  e_uf = primed;
                  cur  = (UR != 0) ? last : '0;
                end
              end
              e_data = exp_bit(cur, d);
              e_lrck = exp_lrck(d);
            end
            if (acc) hold_q.push_back(a_in);
            e_ready = (hold_q.size() == 0);
            #1;
            chk("bck", bck, e_bck);
            chk("lrck", lrck, e_lrck);
            chk("data", data, e_data);
            chk("frame_start", fs, e_fs);
            chk("underflow", uf, e_uf);
            chk("ready", ready, e_ready);
            if (k % BD == 0) cap = {cap[62:0], data};
          end
        end
      end

      initial begin : stim
        int t;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_bck", bck, 0);
        chk("rst_lrck", lrck, 0);
        chk("rst_data", data, 0);
        chk("rst_fs", fs, 0);
        chk("rst_uf", uf, 0);

        @(negedge clk);
        din   = IW'(cfg_first(gi));
        valid = 1'b1;
        rst   = 1'b0;
        while (hold_q.size() == 0 && k < 4) @(negedge clk);
        valid = 1'b0;
        while (k < BD * FB) @(negedge clk);
        chk("frame1_stream", 64'(cap[FB-1:0]), cfg_lit(gi));
        while (k < BD * (FB + 1)) @(negedge clk);
        chk("first_underflow", uf, 1);
        while (k < BD * 2 * FB) @(negedge clk);
        chk("frame2_stream", 64'(cap[FB-1:0]), (UR != 0) ? cfg_lit(gi) : 64'h0);

        for (int c = 0; c < 4 * FP; c++) begin
          @(negedge clk);
          valid = ($urandom_range(0, 15) == 0);
          din   = rnd();
        end

        // Collision: offer a frame on exactly the load clk with the buffer empty.
        @(negedge clk);
        valid = 1'b0;
        repeat (2 * FP) @(negedge clk);
        while (((k + 1 - BD) % FP) != 0) @(negedge clk);
        valid = 1'b1;
        din   = rnd();
        @(negedge clk);
        valid = 1'b0;
        chk("col_fs", fs, 1);
        chk("col_uf", uf, 1);
        chk("col_ready", ready, 0);
        repeat (FP) @(negedge clk);
        chk("col_next_fs", fs, 1);
        chk("col_next_uf", uf, 0);
        chk("col_next_ready", ready, 1);

        // Asynchronous reset in the middle of a slot.
        repeat ($urandom_range(FP / 2, FP)) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_bck", bck, 0);
        chk("arst_lrck", lrck, 0);
        chk("arst_data", data, 0);
        chk("arst_fs", fs, 0);
        chk("arst_uf", uf, 0);
        chk("arst_ready", ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (fs !== 1'b1 && t < 4 * BD);
        chk("arst_to_fs", 64'(t), 64'(BD));
        chk("arst_fs_ready", ready, 1);
        chk("arst_fs_no_uf", uf, 0);

        for (int c = 0; c < 6 * FP; c++) begin
          @(negedge clk);
          valid = ($urandom_range(0, 2 * FP) == 0);
          din   = rnd();
        end
        @(negedge clk);
        valid = 1'b0;
        done  = 1'b1;
      end
    end
  endgenerate

  initial begin : main
    int cyc;
    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 80000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 80000) begin
      n_checks++;
      $display("FAIL timeout: got %0d cycles expected completion of all configs", cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
